data_pack: RTL

Packs a stream of LSB-aligned 7-bit values into LSB-first 32-bit words with packet framing. It is the transmit-side inverse of the 32-to-7 unpacker, so the 7-bit stream reconstructs to the same 32-bit words. A packet is bounded by `sop_in`/`eop_in`. A partial final word is zero-padded in its upper bits. A registered valid/ready output stage supports downstream back-pressure.

---
 rtl/data_pack.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/data_pack.sv
// data_pack: packs LSB-aligned 7-bit values into LSB-first 32-bit words with sop/eop framing.
// Optional macro DATA_PACK_ABORT_EN: sop_in inside an open packet aborts it and starts a new one.
`default_nettype none

module data_pack (
  input  logic        clk,
  input  logic        rst,
  output logic        ready_out,
  input  logic        valid_in,
  input  logic [6:0]  data_in,
  input  logic        sop_in,
  input  logic        eop_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] data_out,
  output logic        sop_out,
  output logic        eop_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state_q;
  logic [37:0] acc_q;
  logic [5:0]  fill_q;
  logic        first_q;
  logic        valid_q;
  logic [31:0] data_q;
  logic        sop_q;
  logic        eop_q;

  logic        out_free;
  logic        accept;
  logic        start;
  logic        in_pkt;
  logic [37:0] base_acc_d;
  logic [5:0]  base_fill_d;
  logic        base_first_d;
  logic [37:0] ins_acc_d;
  logic [5:0]  ins_fill_d;

  assign out_free  = !valid_q || ready_in;
  assign ready_out = !rst && (state_q != S_FLUSH) && out_free;
  assign accept    = valid_in && ready_out;

`ifdef DATA_PACK_ABORT_EN
  assign start = sop_in && (state_q != S_FLUSH);
`else
  assign start = sop_in && (state_q == S_IDLE);
`endif
  assign in_pkt = start || (state_q == S_PACK);

  // A starting value inserts into an empty accumulator, dropping any aborted partial bits.
  always_comb begin
    base_acc_d   = start ? 38'd0 : acc_q;
    base_fill_d  = start ? 6'd0  : fill_q;
    base_first_d = start ? 1'b1  : first_q;
    ins_acc_d    = base_acc_d | ({31'd0, data_in} << base_fill_d);
    ins_fill_d   = base_fill_d + 6'd7;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 38'd0;
      fill_q  <= 6'd0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      if (valid_q && ready_in) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_PACK: begin
          if (accept && in_pkt) begin
            if (eop_in) begin
              valid_q <= 1'b1;
              data_q  <= ins_acc_d[31:0];
              sop_q   <= base_first_d;
              first_q <= 1'b0;
              if (ins_fill_d <= 6'd32) begin
                eop_q   <= 1'b1;
                state_q <= S_IDLE;
                acc_q   <= 38'd0;
                fill_q  <= 6'd0;
              end else begin
                eop_q   <= 1'b0;
                state_q <= S_FLUSH;
                acc_q   <= ins_acc_d >> 32;
                fill_q  <= ins_fill_d - 6'd32;
              end
            end else if (ins_fill_d >= 6'd32) begin
              valid_q <= 1'b1;
              data_q  <= ins_acc_d[31:0];
              sop_q   <= base_first_d;
              eop_q   <= 1'b0;
              first_q <= 1'b0;
              state_q <= S_PACK;
              acc_q   <= ins_acc_d >> 32;
              fill_q  <= ins_fill_d - 6'd32;
            end else begin
              first_q <= base_first_d;
              state_q <= S_PACK;
              acc_q   <= ins_acc_d;
              fill_q  <= ins_fill_d;
            end
          end
        end
        S_FLUSH: begin
          // Residual is at most 6 bits, so acc_q[31:0] is already zero-padded.
          if (out_free) begin
            valid_q <= 1'b1;
            data_q  <= acc_q[31:0];
            sop_q   <= first_q;
            eop_q   <= 1'b1;
            first_q <= 1'b0;
            state_q <= S_IDLE;
            acc_q   <= 38'd0;
            fill_q  <= 6'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          acc_q   <= 38'd0;
          fill_q  <= 6'd0;
          first_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;

endmodule

`default_nettype wire
